// File: rtl/ddr_cmd_arbiter.sv
// Round-robin arbiter that shares the controller command input between NUM_REQ requesters.
// Latches the winning address/code, strobes cmd_rdy, then follows the controller busy handshake.
module ddr_cmd_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 40,
  parameter int REQ_W       = 3,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                        CK_t,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*REQ_W-1:0]    req_type,
  output logic [NUM_REQ-1:0]          req_ack,
  input  logic                        busy,
  input  logic                        refresh_rdy,
  output logic                        cmd_rdy,
  output logic [ADDR_W-1:0]           log_addr,
  output logic [REQ_W-1:0]            request,
  output logic [$clog2(NUM_REQ)-1:0]  grant_id,
  output logic                        timeout_err
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

  state_t               state_reg, state_next;
  logic [ID_W-1:0]      rr_ptr_reg, rr_ptr_next;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [NUM_REQ-1:0]   req_ack_reg, req_ack_next;
  logic                 cmd_rdy_reg, cmd_rdy_next;
  logic [ADDR_W-1:0]    log_addr_reg, log_addr_next;
  logic [REQ_W-1:0]     request_reg, request_next;
  logic [ID_W-1:0]      grant_id_reg, grant_id_next;
  logic                 timeout_err_reg, timeout_err_next;

  logic [ADDR_W-1:0]    addr_arr [NUM_REQ];
  logic [REQ_W-1:0]     type_arr [NUM_REQ];
  logic                 win_found;
  logic [ID_W-1:0]      win_idx;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign addr_arr[gi] = req_addr[gi*ADDR_W +: ADDR_W];
      assign type_arr[gi] = req_type[gi*REQ_W +: REQ_W];
    end
  endgenerate

  // Rotating priority search: first valid requester at or after rr_ptr wins.
  always_comb begin
    int cand;
    cand      = 0;
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(rr_ptr_reg) + i) % NUM_REQ;
      if (!win_found && req_valid[ID_W'(cand)]) begin
        win_found = 1'b1;
        win_idx   = ID_W'(cand);
      end
    end
  end

  always_comb begin
    state_next       = state_reg;
    rr_ptr_next      = rr_ptr_reg;
    cnt_next         = cnt_reg;
    req_ack_next     = '0;
    cmd_rdy_next     = 1'b0;
    log_addr_next    = log_addr_reg;
    request_next     = request_reg;
    grant_id_next    = grant_id_reg;
    timeout_err_next = timeout_err_reg;
    case (state_reg)
      IDLE: begin
        if (!refresh_rdy && !busy && win_found) begin
          log_addr_next         = addr_arr[win_idx];
          request_next          = type_arr[win_idx];
          grant_id_next         = win_idx;
          req_ack_next[win_idx] = 1'b1;
          cmd_rdy_next          = 1'b1;
          rr_ptr_next           = (win_idx == ID_LAST) ? '0 : win_idx + 1'b1;
          state_next            = ISSUE;
        end
      end
      ISSUE: begin
        cnt_next   = '0;
        state_next = WAIT_ACK;
      end
      WAIT_ACK: begin
        cnt_next = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + 1'b1;
        // busy takes priority over an expiring timeout on the same edge
        if (busy) begin
          state_next = WAIT_DONE;
        end else if (cnt_reg >= CNT_LAST) begin
          timeout_err_next = 1'b1;
          state_next       = IDLE;
        end
      end
      WAIT_DONE: begin
        if (!busy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge CK_t) begin
    if (reset) begin
      state_reg       <= IDLE;
      rr_ptr_reg      <= '0;
      cnt_reg         <= '0;
      req_ack_reg     <= '0;
      cmd_rdy_reg     <= 1'b0;
      log_addr_reg    <= '0;
      request_reg     <= '0;
      grant_id_reg    <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      rr_ptr_reg      <= rr_ptr_next;
      cnt_reg         <= cnt_next;
      req_ack_reg     <= req_ack_next;
      cmd_rdy_reg     <= cmd_rdy_next;
      log_addr_reg    <= log_addr_next;
      request_reg     <= request_next;
      grant_id_reg    <= grant_id_next;
      timeout_err_reg <= timeout_err_next;
    end
  end

  assign req_ack     = req_ack_reg;
  assign cmd_rdy     = cmd_rdy_reg;
  assign log_addr    = log_addr_reg;
  assign request     = request_reg;
  assign grant_id    = grant_id_reg;
  assign timeout_err = timeout_err_reg;

endmodule
